// File: rtl/tt_um_enieman.sv
// -----------------------------------------------------------------------------
// tt_um_enieman
//   TinyTapeout top level of the UART-programmable RV32I project. A host talks
//   to the chip over an 8N1 UART and gets byte-level access to a 16 x 32-bit
//   program/data memory, an 8-bit GPIO output register and an 8-bit GPIO
//   output-enable register. It can also sample the GPIO input pins.
//
//   Command set (first byte selects the command):
//     'W' addr d0 d1 d2 d3 -> mem[addr[3:0]] = {d3,d2,d1,d0}, reply ACK (0x06)
//     'R' addr             -> reply mem[addr[3:0]] as 4 bytes, d0 first
//     'O' val              -> uio_out = val, reply ACK
//     'E' val              -> uio_oe  = val, reply ACK
//     'I'                  -> reply uio_in as sampled when 'I' completes
//     anything else        -> reply NAK (0x15)
//
// Ports:
//   clk     system clock, all logic on the rising edge
//   rst_n   asynchronous active-low reset
//   ena     design-selected strobe (unused)
//   ui_in   [0] uart_rx (idle high), [7:1] unused
//   uo_out  [0] uart_tx, [1] busy, [2] frame_err, [7:3] zero
//   uio_in  GPIO input pins
//   uio_out GPIO output register
//   uio_oe  GPIO output-enable register (1 = drive)
// -----------------------------------------------------------------------------
module tt_um_enieman #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_O = 8'h4F;
    localparam logic [7:0] CMD_E = 8'h45;
    localparam logic [7:0] CMD_I = 8'h49;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[7:1]};

    // -------------------------------------------------------------------------
    // UART receiver
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state;
    logic [1:0]  rx_sync;
    logic        rx_prev;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_err;
    logic        frame_err;
    logic        rx_s;

    assign rx_s = rx_sync[1];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            rx_sync   <= 2'b11;
            rx_prev   <= 1'b1;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], ui_in[0]};
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        rx_bit  <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_state <= RX_IDLE;
                        if (rx_s) begin
                            rx_valid  <= 1'b1;
                            frame_err <= 1'b0;
                        end else begin
                            rx_err    <= 1'b1;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // UART transmitter
    // -------------------------------------------------------------------------
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active;
    logic [8:0]  tx_shift;   // data bits still to send, stop bit on top
    logic [3:0]  tx_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [15:0] tx_cnt;
    logic        uart_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_active <= 1'b0;
            tx_shift  <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
            uart_tx   <= 1'b1;
        end else if (!tx_active) begin
            if (tx_start) begin
                tx_active <= 1'b1;
                tx_shift  <= {1'b1, tx_data};
                tx_bit    <= '0;
                tx_cnt    <= '0;
                uart_tx   <= 1'b0;
            end
        end else if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_active <= 1'b0;
                uart_tx   <= 1'b1;
            end else begin
                tx_bit   <= tx_bit + 4'd1;
                uart_tx  <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
            end
        end else begin
            tx_cnt <= tx_cnt + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Command parser
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, GET_VAL, REPLY} p_state_t;

    p_state_t    state, next_state;
    logic [7:0]  cmd;
    logic [3:0]  addr;
    logic [23:0] data_buf;     // {d2,d1,d0} once three data bytes are in
    logic [1:0]  byte_cnt;
    logic [31:0] reply_buf;    // next byte to send in [7:0]
    logic [2:0]  reply_left;
    logic [31:0] mem [16];

    logic        capture_cmd, capture_addr, capture_data;
    logic        mem_we, out_we, oe_we;
    logic        load_reply;
    logic [31:0] reply_val;
    logic [2:0]  reply_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state   = state;
        capture_cmd  = 1'b0;
        capture_addr = 1'b0;
        capture_data = 1'b0;
        mem_we       = 1'b0;
        out_we       = 1'b0;
        oe_we        = 1'b0;
        load_reply   = 1'b0;
        reply_val    = 32'h0;
        reply_len    = 3'd0;
        tx_start     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    capture_cmd = 1'b1;
                    case (rx_byte)
                        CMD_W, CMD_R: next_state = GET_ADDR;
                        CMD_O, CMD_E: next_state = GET_VAL;
                        CMD_I: begin
                            next_state = REPLY;
                            load_reply = 1'b1;
                            reply_val  = {24'h0, uio_in};
                            reply_len  = 3'd1;
                        end
                        default: begin
                            next_state = REPLY;
                            load_reply = 1'b1;
                            reply_val  = {24'h0, NAK};
                            reply_len  = 3'd1;
                        end
                    endcase
                end
            end
            GET_ADDR: begin
                if (rx_err) begin
                    next_state = IDLE;
                end else if (rx_valid) begin
                    capture_addr = 1'b1;
                    if (cmd == CMD_R) begin
                        next_state = REPLY;
                        load_reply = 1'b1;
                        reply_val  = mem[rx_byte[3:0]];
                        reply_len  = 3'd4;
                    end else begin
                        next_state = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (rx_err) begin
                    next_state = IDLE;
                end else if (rx_valid) begin
                    if (byte_cnt == 2'd3) begin
                        mem_we     = 1'b1;
                        next_state = REPLY;
                        load_reply = 1'b1;
                        reply_val  = {24'h0, ACK};
                        reply_len  = 3'd1;
                    end else begin
                        capture_data = 1'b1;
                    end
                end
            end
            GET_VAL: begin
                if (rx_err) begin
                    next_state = IDLE;
                end else if (rx_valid) begin
                    out_we     = (cmd == CMD_O);
                    oe_we      = (cmd == CMD_E);
                    next_state = REPLY;
                    load_reply = 1'b1;
                    reply_val  = {24'h0, ACK};
                    reply_len  = 3'd1;
                end
            end
            REPLY: begin
                // Incoming bytes are ignored here; leave once the last stop
                // bit has gone out.
                if (reply_left != 3'd0) tx_start = !tx_active;
                else if (!tx_active)    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign tx_data = reply_buf[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd        <= '0;
            addr       <= '0;
            data_buf   <= '0;
            byte_cnt   <= '0;
            reply_buf  <= '0;
            reply_left <= '0;
            uio_out    <= '0;
            uio_oe     <= '0;
        end else begin
            if (capture_cmd) cmd <= rx_byte;
            if (capture_addr) begin
                addr     <= rx_byte[3:0];
                byte_cnt <= '0;
            end
            if (capture_data) begin
                data_buf <= {rx_byte, data_buf[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (out_we) uio_out <= rx_byte;
            if (oe_we)  uio_oe  <= rx_byte;
            if (load_reply) begin
                reply_buf  <= reply_val;
                reply_left <= reply_len;
            end else if (tx_start) begin
                reply_buf  <= {8'h0, reply_buf[31:8]};
                reply_left <= reply_left - 3'd1;
            end
        end
    end

    // NOTE: the memory is a register array that must read as zero after
    // reset, so it sits on the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[addr] <= {rx_byte, data_buf};
        end
    end

    assign uo_out = {5'b0, frame_err, (state != IDLE), uart_tx};

endmodule

// File: tb/tb_tt_um_enieman.sv
// -----------------------------------------------------------------------------
// tb_tt_um_enieman
//   Scoreboard bench for tt_um_enieman. The stimulus process drives UART
//   frames into ui_in[0] and pushes each expected reply byte into exp_q; a
//   monitor process decodes uo_out[0] independently and compares each received
//   byte with the head of the queue. Register/flag checks are done inline.
// -----------------------------------------------------------------------------
module tb_tt_um_enieman;

    localparam int CPB = 16;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h01;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    tt_um_enieman #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
        @(negedge clk);
        ui_in[0] = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ui_in[0] = b[i];
            repeat (CPB) @(negedge clk);
        end
        ui_in[0] = good_stop;
        repeat (CPB) @(negedge clk);
        ui_in[0] = 1'b1;
        repeat (good_stop ? 2 : CPB) @(negedge clk);
    endtask

    task automatic expect_bytes(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    // Wait for all expected replies to arrive and the parser to go idle.
    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || uo_out[1]) && n < 60 * CPB) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, (exp_q.size() == 0 && !uo_out[1])}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: decode every frame on uart_tx and score it.
    initial begin : monitor
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge uo_out[0]);
            if (rst_n) begin
                repeat (CPB / 2) @(negedge clk);
                check("tx_start_bit", {31'b0, uo_out[0]}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uo_out[0];
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", {31'b0, uo_out[0]}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_reply: got 0x%0h expected none", b);
                end else begin
                    e = exp_q.pop_front();
                    check("reply_byte", {24'b0, b}, {24'b0, e});
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset
        #2 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_uo_out_held", {24'b0, uo_out}, 32'h01);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_uo_out", {24'b0, uo_out}, 32'h01);
        check("reset_uio_out", {24'b0, uio_out}, 32'h00);
        check("reset_uio_oe", {24'b0, uio_oe}, 32'h00);
        expect_bytes(32'h0000_0000, 4);
        send_byte(8'h52); send_byte(8'h05);
        wait_idle("read_after_reset");

        // Write / read / wrap
        expect_bytes(32'h06, 1);
        send_byte(8'h57); send_byte(8'h03);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_idle("write_03");
        expect_bytes(32'hDEAD_BEEF, 4);
        send_byte(8'h52); send_byte(8'h03);
        wait_idle("read_03");
        expect_bytes(32'hDEAD_BEEF, 4);
        send_byte(8'h52); send_byte(8'h13);
        wait_idle("read_13_wrap");
        expect_bytes(32'h06, 1);
        send_byte(8'h57); send_byte(8'hFF);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_idle("write_0f");
        expect_bytes(32'h0403_0201, 4);
        send_byte(8'h52); send_byte(8'h0F);
        wait_idle("read_0f");
        expect_bytes(32'h0000_0000, 4);
        send_byte(8'h52); send_byte(8'h04);
        wait_idle("read_04_untouched");

        // GPIO
        expect_bytes(32'h06, 1);
        send_byte(8'h4F); send_byte(8'hA5);
        wait_idle("gpio_out_cmd");
        check("uio_out_a5", {24'b0, uio_out}, 32'hA5);
        expect_bytes(32'h06, 1);
        send_byte(8'h45); send_byte(8'hFF);
        wait_idle("gpio_oe_cmd");
        check("uio_oe_ff", {24'b0, uio_oe}, 32'hFF);
        uio_in = 8'h3C;
        expect_bytes(32'h3C, 1);
        send_byte(8'h49);
        wait_idle("gpio_in_3c");

        // Unknown command, then a normal read
        expect_bytes(32'h15, 1);
        send_byte(8'h00);
        wait_idle("nak_00");
        expect_bytes(32'h0000_0000, 4);
        send_byte(8'h52); send_byte(8'h00);
        wait_idle("read_00_after_nak");

        // Framing error while idle: sticky flag, no reply
        send_byte(8'h57, 1'b0);
        check("frame_err_set", {31'b0, uo_out[2]}, 32'd1);
        check("busy_after_bad_frame", {31'b0, uo_out[1]}, 32'd0);
        uio_in = 8'h5A;
        expect_bytes(32'h5A, 1);
        send_byte(8'h49);
        check("frame_err_cleared", {31'b0, uo_out[2]}, 32'd0);
        wait_idle("gpio_in_after_ferr");

        // Framing error mid-command aborts without writing
        send_byte(8'h4F);
        check("busy_mid_cmd", {31'b0, uo_out[1]}, 32'd1);
        send_byte(8'h11, 1'b0);
        check("abort_busy", {31'b0, uo_out[1]}, 32'd0);
        check("abort_uio_out", {24'b0, uio_out}, 32'hA5);
        check("abort_frame_err", {31'b0, uo_out[2]}, 32'd1);

        // Reset in the middle of a partial write
        send_byte(8'h57); send_byte(8'h01); send_byte(8'hAA);
        check("busy_partial_write", {31'b0, uo_out[1]}, 32'd1);
        @(negedge clk);
        ui_in[0] = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_uo_out", {24'b0, uo_out}, 32'h01);
        ui_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_busy", {31'b0, uo_out[1]}, 32'd0);
        check("post_reset_uio_out", {24'b0, uio_out}, 32'h00);
        check("post_reset_uio_oe", {24'b0, uio_oe}, 32'h00);
        expect_bytes(32'h0000_0000, 4);
        send_byte(8'h52); send_byte(8'h01);
        wait_idle("read_01_after_reset");
        expect_bytes(32'h0000_0000, 4);
        send_byte(8'h52); send_byte(8'h03);
        wait_idle("read_03_after_reset");

        // Give any stray reply time to show up in the monitor
        repeat (12 * CPB) @(negedge clk);
        check("no_pending_replies", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
